mul_accumulate_stage: RTL and testbench
=======================================

Name: mul_accumulate_stage

Overview:
- Sequential consumer placed directly downstream of the combinational 32x32 signed Booth multiplier.
- Takes each signed 64-bit product through a valid/ready handshake and accumulates a sequence of products into a guarded accumulator. Supported operations are add, subtract, load and clear.
- At the last product of a sequence it presents the 64-bit saturated sum with a valid/ready handshake.
- Provides the MAC / dot-product capability that the datapath builds on the multiplier.

Parameters:
- PROD_W, 64: product width; must match the multiplier result width.
- ACC_W, 72: internal accumulator width, two's complement; ACC_W > PROD_W gives guard bits.
- CNT_W, 16: width of the product counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- prod_valid, input, 1: a product is offered.
- prod_ready, output, 1: the stage can accept a product this cycle.
- prod, input, PROD_W: signed product from the multiplier.
- prod_op, input, 2: 00 ADD, 01 SUB, 10 LOAD (acc = prod), 11 CLEAR (acc = 0, prod ignored).
- prod_last, input, 1: this product closes the sequence.
- acc_valid, output, 1: the result is presented.
- acc_ready, input, 1: the consumer takes the result.
- acc_out, output, PROD_W: signed result, saturated to the PROD_W range.
- acc_sat, output, 1: the result was clipped, or the internal accumulator saturated during the sequence.
- acc_count, output, CNT_W: number of products accepted in the sequence, including CLEAR.

Behaviour:
- Reset:
  - rst is sampled at the clock edge and has priority over every handshake.
  - It forces state to IDLE; accumulator, sat_sticky and count to 0; acc_valid 0; acc_out 0; acc_sat 0; acc_count 0.
  - A reset mid-sequence or in HOLD discards all data; no partial result is ever presented.
- States:
  - IDLE: no sequence open; prod_ready = 1.
  - ACCUM: sequence open; prod_ready = 1.
  - HOLD: result presented; prod_ready = 0.
- Accept: occurs when prod_valid & prod_ready at the edge.
- prod_ready is a pure function of state, never of prod_valid or acc_ready.
- Accepting a product updates the accumulator:
  - The working value is computed at ACC_W+1 bits: sign-extend prod to ACC_W+1, then acc ± prod.
  - The working value is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. If clamping occurs, sat_sticky is set.
  - LOAD: acc = sign-extended prod, and sat_sticky is cleared.
  - CLEAR: acc = 0, and sat_sticky is cleared.
- Count on accept:
  - count = count+1, saturating at 2^CNT_W-1.
  - If the current state is IDLE, count = 1 (the new sequence starts fresh).
- State transitions on accept:
  - prod_last = 0: go to ACCUM.
  - prod_last = 1: go to HOLD.
- Entering HOLD:
  - acc_valid = 1 from the cycle after the accepting edge (latency 1).
  - acc_out = the new accumulator value clamped to the PROD_W signed range.
  - acc_sat = sat_sticky (including this update) OR the output clamp occurred.
  - acc_count = the new count.
- Output stability: acc_out, acc_sat and acc_count stay constant while acc_valid = 1 and acc_ready = 0.
- Leaving HOLD:
  - On acc_valid & acc_ready: go to IDLE, clear the accumulator, sat_sticky and count, and drop acc_valid next cycle.
  - acc_out, acc_sat and acc_count are driven to 0 in IDLE.
  - Minimum gap between two results is 2 cycles (the HOLD handshake, then an IDLE accept).
- Products offered while in HOLD are stalled, not dropped. The producer must hold prod, prod_op and prod_last stable until accepted.
- Internal visibility: in IDLE and ACCUM, acc_valid = 0; internal partial sums are not visible.
- Single-element sequence: a single-product sequence (IDLE accept with prod_last = 1) goes straight to HOLD.

Test Plan:
- Basic sequence: ADD prod = -12 (3 × -4), then ADD 20, then SUB 5 with last = 1; acc_ready = 1 → acc_valid is high for 1 cycle, starting one cycle after the last accept, with acc_out = 3, acc_count = 3, acc_sat = 0.
- Consumer back-pressure: LOAD 7 with last = 1 and acc_ready = 0 for 5 cycles → acc_out = 7 held stable, prod_ready = 0 throughout, and the offered next product is not accepted until the cycle after the acc_ready handshake.
- Positive saturation: ADD 0x7FFF_FFFF_FFFF_FFFF twice with last on the second → acc_out = 0x7FFF_FFFF_FFFF_FFFF, acc_sat = 1.
- Negative saturation: repeat the saturation sequence with SUB from 0 → acc_out = 0x8000_0000_0000_0000, acc_sat = 1.
- Clipped value cleared by CLEAR: ADD 0x7FFF_FFFF_FFFF_FFFF, ADD 1, then CLEAR, then ADD 9 with last → acc_out = 9, acc_sat = 0, acc_count = 4.
- Reset mid-sequence: ADD 100, ADD 50, assert rst for 1 cycle, then ADD 1 with last → acc_out = 1, acc_count = 1; no acc_valid pulse occurs before it.

Source files
------------

// File: rtl/mul_accumulate_stage_if.sv
// rtl/mul_accumulate_stage_if.sv - product/result handshake bundle for the accumulate stage
//
// Purpose: groups the product input stream and the result output stream.
// Ports (signals):
//   prod_valid/prod_ready  product handshake
//   prod, prod_op          signed product, operation (00 ADD, 01 SUB, 10 LOAD, 11 CLEAR)
//   prod_last              product closes the sequence
//   acc_valid/acc_ready    result handshake
//   acc_out, acc_sat       saturated result and saturation flag
//   acc_count              products accepted in the sequence
// Modports: master = producer/consumer side, slave = accumulate stage.
interface mul_accumulate_stage_if #(
    parameter int PROD_W = 64,
    parameter int CNT_W  = 16
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod;
    logic [1:0]        prod_op;
    logic              prod_last;
    logic              acc_valid;
    logic              acc_ready;
    logic [PROD_W-1:0] acc_out;
    logic              acc_sat;
    logic [CNT_W-1:0]  acc_count;

    modport master (
        output prod_valid, prod, prod_op, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_out, acc_sat, acc_count
    );

    modport slave (
        input  prod_valid, prod, prod_op, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_out, acc_sat, acc_count
    );
endinterface

// File: rtl/mul_accumulate_stage.sv
// rtl/mul_accumulate_stage.sv - guarded multiply-accumulate stage behind the Booth multiplier
//
// Purpose: accepts signed products, accumulates a sequence (ADD/SUB/LOAD/CLEAR) into a
// guarded ACC_W accumulator and presents the PROD_W-saturated sum at the sequence end.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   mul_accumulate_stage_if.slave: product stream in, result stream out
module mul_accumulate_stage #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_accumulate_stage_if.slave bus
);

    localparam int WRK_W = ACC_W + 1;
    localparam int GRD_W = ACC_W - PROD_W;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [PROD_W-1:0] PROD_MAX = {1'b0, {(PROD_W-1){1'b1}}};
    localparam logic [PROD_W-1:0] PROD_MIN = {1'b1, {(PROD_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] out_q, out_d;
    logic              out_sat_q, out_sat_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic prod_ready;
    logic acc_valid;
    logic prod_fire;
    logic acc_fire;

    assign prod_fire = bus.prod_valid & prod_ready;
    assign acc_fire  = acc_valid & bus.acc_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (prod_fire) begin
                    state_d = bus.prod_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (acc_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, pure functions of state
    // ------------------------------------------------------------------
    always_comb begin
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        case (state_q)
            S_IDLE:  prod_ready = 1'b1;
            S_ACCUM: prod_ready = 1'b1;
            S_HOLD:  acc_valid  = 1'b1;
            default: begin
                prod_ready = 1'b0;
                acc_valid  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate datapath
    // ------------------------------------------------------------------
    logic [WRK_W-1:0]  prod_ext;
    logic [WRK_W-1:0]  acc_ext;
    logic [WRK_W-1:0]  work;
    logic              work_pos_ovf;
    logic              work_neg_ovf;
    logic [ACC_W-1:0]  acc_new;
    logic              sticky_new;
    logic [CNT_W-1:0]  cnt_new;
    logic              out_pos_clip;
    logic              out_neg_clip;
    logic [PROD_W-1:0] out_new;
    logic              seq_open;

    // In IDLE the previous sequence is treated as absent, so a stale
    // accumulator or flag can never leak into a new sequence.
    assign seq_open = (state_q == S_ACCUM);

    always_comb begin
        prod_ext = {{(WRK_W-PROD_W){bus.prod[PROD_W-1]}}, bus.prod};
        acc_ext  = seq_open ? {acc_q[ACC_W-1], acc_q} : '0;

        case (bus.prod_op)
            OP_ADD:   work = acc_ext + prod_ext;
            OP_SUB:   work = acc_ext - prod_ext;
            OP_LOAD:  work = prod_ext;
            OP_CLEAR: work = '0;
            default:  work = '0;
        endcase

        // One extra bit is enough to hold any acc +/- prod, so the top two
        // bits disagreeing means the ACC_W range was left.
        work_pos_ovf = ~work[WRK_W-1] &  work[WRK_W-2];
        work_neg_ovf =  work[WRK_W-1] & ~work[WRK_W-2];

        if (work_pos_ovf) begin
            acc_new = ACC_MAX;
        end else if (work_neg_ovf) begin
            acc_new = ACC_MIN;
        end else begin
            acc_new = work[ACC_W-1:0];
        end

        if (bus.prod_op == OP_LOAD || bus.prod_op == OP_CLEAR) begin
            sticky_new = 1'b0;
        end else begin
            sticky_new = (seq_open & sat_q) | work_pos_ovf | work_neg_ovf;
        end

        if (!seq_open) begin
            cnt_new = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_new = cnt_q;
        end else begin
            cnt_new = cnt_q + CNT_W'(1);
        end

        // The value fits PROD_W only when the guard bits and the PROD_W sign
        // bit all equal the accumulator sign.
        out_pos_clip = ~acc_new[ACC_W-1] &  (|acc_new[ACC_W-2:PROD_W-1]);
        out_neg_clip =  acc_new[ACC_W-1] & ~(&acc_new[ACC_W-2:PROD_W-1]);

        if (out_pos_clip) begin
            out_new = PROD_MAX;
        end else if (out_neg_clip) begin
            out_new = PROD_MIN;
        end else begin
            out_new = acc_new[PROD_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Accumulator / result next state
    // ------------------------------------------------------------------
    always_comb begin
        acc_d     = acc_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_sat_d = out_sat_q;
        out_cnt_d = out_cnt_q;

        if (state_q == S_HOLD) begin
            if (acc_fire) begin
                acc_d     = '0;
                sat_d     = 1'b0;
                cnt_d     = '0;
                out_d     = '0;
                out_sat_d = 1'b0;
                out_cnt_d = '0;
            end
        end else if (prod_fire) begin
            acc_d = acc_new;
            sat_d = sticky_new;
            cnt_d = cnt_new;
            if (bus.prod_last) begin
                out_d     = out_new;
                out_sat_d = sticky_new | out_pos_clip | out_neg_clip;
                out_cnt_d = cnt_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_sat_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_sat_q <= out_sat_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Result registers are only loaded when entering HOLD and are zeroed on
    // leaving it, so they already read 0 in IDLE and ACCUM.
    always_comb begin
        bus.prod_ready = prod_ready;
        bus.acc_valid  = acc_valid;
        bus.acc_out    = out_q;
        bus.acc_sat    = out_sat_q;
        bus.acc_count  = out_cnt_q;
    end

    // Guard bits must exist for the output clamp slice to be meaningful.
    if (GRD_W < 1) begin : g_bad_width
        $error("ACC_W must exceed PROD_W");
    end

endmodule

// File: tb/tb_mul_accumulate_stage.sv
// tb/tb_mul_accumulate_stage.sv - randomized and directed bench for mul_accumulate_stage
module tb_mul_accumulate_stage;

    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;
    localparam int CNT_W  = 16;

    localparam logic signed [127:0] ACC_MAX = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
    localparam logic signed [127:0] ACC_MIN = -(128'sd1 <<< (ACC_W-1));
    localparam logic signed [127:0] P_MAX   = (128'sd1 <<< (PROD_W-1)) - 128'sd1;
    localparam logic signed [127:0] P_MIN   = -(128'sd1 <<< (PROD_W-1));
    localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;

    mul_accumulate_stage_if #(.PROD_W(PROD_W), .CNT_W(CNT_W)) bus ();

    mul_accumulate_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit check_en = 1'b0;
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        bus.acc_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: the sequence is just a signed sum clamped to the
    // accumulator range, then the final sum clamped to the product range.
    int                   m_phase;   // 0 no sequence, 1 sequence open, 2 result shown
    logic signed [127:0]  m_acc;
    bit                   m_sticky;
    int                   m_cnt;
    logic [63:0]          m_out;
    bit                   m_sat;
    int                   m_rcnt;

    logic [63:0] r_out[$];
    bit          r_sat[$];
    int          r_cnt[$];
    int          vcyc = 0;
    int          hs_cyc = -1;
    int          acc_cyc = -1;

    always @(negedge clk) begin
        logic signed [127:0] p, w, o;
        bit clip;
        if (check_en) begin
            chk("prod_ready", bus.prod_ready, m_phase != 2);
            chk("acc_valid", bus.acc_valid, m_phase == 2);
            chk("acc_out", bus.acc_out, (m_phase == 2) ? m_out : 64'd0);
            chk("acc_sat", bus.acc_sat, (m_phase == 2) ? m_sat : 1'b0);
            chk("acc_count", bus.acc_count, (m_phase == 2) ? m_rcnt : 0);
        end
        if (bus.acc_valid === 1'b1) vcyc++;
        if (rst !== 1'b0) begin
            m_phase = 0; m_acc = 0; m_sticky = 0; m_cnt = 0;
        end else if (m_phase == 2) begin
            if (bus.acc_ready) begin
                r_out.push_back(bus.acc_out);
                r_sat.push_back(bus.acc_sat);
                r_cnt.push_back(int'(bus.acc_count));
                hs_cyc = cyc;
                m_phase = 0; m_acc = 0; m_sticky = 0; m_cnt = 0;
            end
        end else if (bus.prod_valid) begin
            acc_cyc = cyc;
            p = $signed(bus.prod);
            if (m_phase == 0) begin
                m_acc = 0; m_sticky = 0; m_cnt = 0;
            end
            case (bus.prod_op)
                2'b00: w = m_acc + p;
                2'b01: w = m_acc - p;
                2'b10: begin w = p; m_sticky = 0; end
                default: begin w = 0; m_sticky = 0; end
            endcase
            if (w > ACC_MAX) begin w = ACC_MAX; m_sticky = 1; end
            if (w < ACC_MIN) begin w = ACC_MIN; m_sticky = 1; end
            m_acc = w;
            m_cnt = (m_phase == 0) ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
            if (bus.prod_last) begin
                o = w; clip = 0;
                if (o > P_MAX) begin o = P_MAX; clip = 1; end
                if (o < P_MIN) begin o = P_MIN; clip = 1; end
                m_out = o[63:0];
                m_sat = m_sticky | clip;
                m_rcnt = m_cnt;
                m_phase = 2;
            end else begin
                m_phase = 1;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [63:0] p, input logic last);
        int n;
        n = 0;
        bus.prod_valid = 1'b1;
        bus.prod       = p;
        bus.prod_op    = op;
        bus.prod_last  = last;
        forever begin
            @(negedge clk);
            if (bus.prod_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: product not accepted within %0d cycles", n);
                break;
            end
        end
        @(posedge clk); #1;
        bus.prod_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_last(input string nm, input logic [63:0] eo, input bit es, input int ec);
        if (r_out.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: no result observed, expected %0h", nm, eo);
        end else begin
            chk({nm, "_out"}, r_out[$], eo);
            chk({nm, "_sat"}, r_sat[$], es);
            chk({nm, "_cnt"}, r_cnt[$], ec);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nres;
        rst = 1'b1;
        bus.prod_valid = 1'b0;
        bus.prod = '0;
        bus.prod_op = 2'b00;
        bus.prod_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_prod_ready", bus.prod_ready, 1'b1);
        chk("rst_acc_valid", bus.acc_valid, 1'b0);
        chk("rst_acc_out", bus.acc_out, 64'd0);
        chk("rst_acc_count", bus.acc_count, 16'd0);
        @(posedge clk); #1;

        // Basic sequence: -12 + 20 - 5 = 3
        rdy_force = 1'b1;
        vcyc = 0;
        send(2'b00, -64'sd12, 1'b0);
        send(2'b00, 64'd20, 1'b0);
        send(2'b01, 64'd5, 1'b1);
        settle();
        check_last("basic", 64'd3, 1'b0, 3);
        chk("basic_valid_cycles", vcyc, 1);

        // Back-pressure: LOAD 7, consumer stalls 5 cycles
        rdy_force = 1'b0;
        send(2'b10, 64'd7, 1'b1);
        bus.prod_valid = 1'b1; bus.prod = 64'd1; bus.prod_op = 2'b00; bus.prod_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_prod_ready", bus.prod_ready, 1'b0);
            chk("bp_acc_out", bus.acc_out, 64'd7);
        end
        @(posedge clk); #1;
        rdy_force = 1'b1;
        send(2'b00, 64'd1, 1'b1);
        chk("bp_accept_gap", acc_cyc, hs_cyc + 1);
        settle();
        chk("bp_first_out", r_out[r_out.size()-2], 64'd7);
        check_last("bp_next", 64'd1, 1'b0, 1);

        // Positive saturation
        send(2'b00, MAX64, 1'b0);
        send(2'b00, MAX64, 1'b1);
        settle();
        check_last("pos_sat", MAX64, 1'b1, 2);

        // Negative saturation
        send(2'b01, MAX64, 1'b0);
        send(2'b01, MAX64, 1'b1);
        settle();
        check_last("neg_sat", MIN64, 1'b1, 2);

        // CLEAR drops earlier overflow
        send(2'b00, MAX64, 1'b0);
        send(2'b00, 64'd1, 1'b0);
        send(2'b11, 64'hDEAD_BEEF, 1'b0);
        send(2'b00, 64'd9, 1'b1);
        settle();
        check_last("clear", 64'd9, 1'b0, 4);

        // Reset mid-sequence discards the partial sum
        nres = r_out.size();
        send(2'b00, 64'd100, 1'b0);
        send(2'b00, 64'd50, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(2'b00, 64'd1, 1'b1);
        settle();
        chk("rst_mid_nres", r_out.size(), nres + 1);
        check_last("rst_mid", 64'd1, 1'b0, 1);

        // Internal accumulator saturation stays sticky: 300*MAX clamps to
        // 2^71-1, then 256 SUBs of MAX land at 255.
        for (int i = 0; i < 300; i++) send(2'b00, MAX64, 1'b0);
        for (int i = 0; i < 255; i++) send(2'b01, MAX64, 1'b0);
        send(2'b01, MAX64, 1'b1);
        settle();
        check_last("int_sat", 64'd255, 1'b1, 556);

        // Count saturates at 2^16-1
        for (int i = 0; i < 65536; i++) send(2'b00, 64'd0, 1'b0);
        send(2'b00, 64'd0, 1'b1);
        settle();
        check_last("cnt_sat", 64'd0, 1'b0, 65535);

        // Randomized sequences with random consumer back-pressure
        rdy_rand = 1'b1;
        for (int s = 0; s < 150; s++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                logic [63:0] pv;
                logic [1:0]  op;
                case ($urandom_range(0, 3))
                    0: pv = {$urandom, $urandom};
                    1: pv = $urandom_range(0, 1) ? MAX64 : MIN64;
                    default: pv = 64'($signed($urandom_range(0, 2000)) - 1000);
                endcase
                case ($urandom_range(0, 9))
                    0: op = 2'b10;
                    1: op = 2'b11;
                    2, 3, 4: op = 2'b01;
                    default: op = 2'b00;
                endcase
                send(op, pv, k == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        settle();
        chk("final_idle", bus.acc_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
